// File: rtl/pcs_pkg.sv
// ---------------------------------------------------------------------------
// pcs_pkg
// Shared constants and types for the 64b/66b receive decoder: sync headers,
// block type fields, XGMII characters, 7-bit control codes, the decoded-block
// record and the state encodings of the decoder FSMs.
// Ports: none (package).
// ---------------------------------------------------------------------------
package pcs_pkg;

  localparam int NUM_LANES = 8;

  // Sync headers
  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  // Block type field (first payload octet of a control block)
  localparam logic [7:0] BT_CTRL   = 8'h1E;
  localparam logic [7:0] BT_START0 = 8'h78;
  localparam logic [7:0] BT_START4 = 8'h33;
  localparam logic [7:0] BT_OS0    = 8'h4B;
  localparam logic [7:0] BT_TERM0  = 8'h87;
  localparam logic [7:0] BT_TERM1  = 8'h99;
  localparam logic [7:0] BT_TERM2  = 8'hAA;
  localparam logic [7:0] BT_TERM3  = 8'hB4;
  localparam logic [7:0] BT_TERM4  = 8'hCC;
  localparam logic [7:0] BT_TERM5  = 8'hD2;
  localparam logic [7:0] BT_TERM6  = 8'hE1;
  localparam logic [7:0] BT_TERM7  = 8'hFF;

  // XGMII characters
  localparam logic [7:0] XG_IDLE  = 8'h07;
  localparam logic [7:0] XG_START = 8'hFB;
  localparam logic [7:0] XG_TERM  = 8'hFD;
  localparam logic [7:0] XG_ERROR = 8'hFE;
  localparam logic [7:0] XG_SEQ   = 8'h9C;

  // 7-bit control codes carried inside control blocks
  localparam logic [6:0] CODE_IDLE  = 7'h00;
  localparam logic [6:0] CODE_ERROR = 7'h1E;

  typedef enum logic [2:0] {
    BLK_DATA    = 3'd0,
    BLK_START   = 3'd1,
    BLK_TERM    = 3'd2,
    BLK_CTRL    = 3'd3,
    BLK_INVALID = 3'd4
  } blk_kind_e;

  typedef struct packed {
    logic [63:0] lanes;
    logic [7:0]  ctrl;
    blk_kind_e   kind;
  } dec_blk_t;

  typedef enum logic {
    IN_W0 = 1'b0,
    IN_W1 = 1'b1
  } in_state_e;

  typedef enum logic {
    FR_IDLE     = 1'b0,
    FR_IN_FRAME = 1'b1
  } frame_state_e;

  // Map a 7-bit control code to its XGMII character; bit 8 flags a legal code.
  function automatic logic [8:0] code_to_char(input logic [6:0] code);
    logic [8:0] res;
    case (code)
      CODE_IDLE:  res = {1'b1, XG_IDLE};
      CODE_ERROR: res = {1'b1, XG_ERROR};
      default:    res = {1'b0, XG_ERROR};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pcs_64b66b_decoder_if.sv
// ---------------------------------------------------------------------------
// pcs_64b66b_decoder_if
// Bundles the encoded-block input beats and the XGMII RX output beats.
//   i_rx_data_valid / i_rx_data / i_rx_sync_hdr : 66b block as two 32b beats
//   o_xgmii_valid / o_xgmii_rxd / o_xgmii_rxc   : decoded XGMII beats
//   o_decoding_err                              : pulse with beat 0 of an /E/ block
// master = block source (drives the i_* side), slave = the decoder.
// ---------------------------------------------------------------------------
interface pcs_64b66b_decoder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4,
  parameter int HDR_WIDTH  = 2
);
  logic                  i_rx_data_valid;
  logic [DATA_WIDTH-1:0] i_rx_data;
  logic [HDR_WIDTH-1:0]  i_rx_sync_hdr;
  logic                  o_xgmii_valid;
  logic [DATA_WIDTH-1:0] o_xgmii_rxd;
  logic [CTRL_WIDTH-1:0] o_xgmii_rxc;
  logic                  o_decoding_err;

  modport master (
    output i_rx_data_valid, i_rx_data, i_rx_sync_hdr,
    input  o_xgmii_valid, o_xgmii_rxd, o_xgmii_rxc, o_decoding_err
  );

  modport slave (
    input  i_rx_data_valid, i_rx_data, i_rx_sync_hdr,
    output o_xgmii_valid, o_xgmii_rxd, o_xgmii_rxc, o_decoding_err
  );
endinterface

// File: rtl/pcs_block_decode.sv
// ---------------------------------------------------------------------------
// pcs_block_decode
// Purely combinational decode of one 66b block into 8 XGMII lanes.
//   sync_hdr : 2-bit sync header
//   payload  : 64-bit block payload, P[7:0] is the block type on control blocks
//   blk      : decoded lanes, per-lane control flags and block kind
// Any structural problem (bad header, unknown type, illegal code, non-zero
// O code) yields an all-/E/ block of kind BLK_INVALID.
// ---------------------------------------------------------------------------
module pcs_block_decode
  import pcs_pkg::*;
(
  input  logic [1:0]  sync_hdr,
  input  logic [63:0] payload,
  output dec_blk_t    blk
);

  logic [71:0] p_ext_s;     // zero-padded so lane selects never run off the top
  logic [7:0]  btype_s;
  logic        is_term_s;
  logic [2:0]  term_k_s;
  logic [63:0] lanes_s;
  logic [7:0]  ctrl_s;
  blk_kind_e   kind_s;
  logic        bad_s;
  logic [8:0]  map_s;

  assign p_ext_s = {8'h00, payload};
  assign btype_s = payload[7:0];

  // Identify terminate block types and the lane that carries /T/
  always_comb begin
    is_term_s = 1'b1;
    term_k_s  = 3'd0;
    case (btype_s)
      BT_TERM0: term_k_s = 3'd0;
      BT_TERM1: term_k_s = 3'd1;
      BT_TERM2: term_k_s = 3'd2;
      BT_TERM3: term_k_s = 3'd3;
      BT_TERM4: term_k_s = 3'd4;
      BT_TERM5: term_k_s = 3'd5;
      BT_TERM6: term_k_s = 3'd6;
      BT_TERM7: term_k_s = 3'd7;
      default: begin
        is_term_s = 1'b0;
        term_k_s  = 3'd0;
      end
    endcase
  end

  // Build lanes, control flags and kind for each block format
  always_comb begin
    lanes_s = {NUM_LANES{XG_ERROR}};
    ctrl_s  = 8'hFF;
    kind_s  = BLK_INVALID;
    bad_s   = 1'b0;
    map_s   = 9'h000;
    case (sync_hdr)
      SYNC_DATA: begin
        lanes_s = payload;
        ctrl_s  = 8'h00;
        kind_s  = BLK_DATA;
      end
      SYNC_CTRL: begin
        if (is_term_s) begin
          kind_s = BLK_TERM;
          // Codes after /T/ land at P[8+7i]: the pad bits between the last
          // data octet and the first code collapse the offset to that form.
          for (int i = 0; i < NUM_LANES; i++) begin
            if (i < int'(term_k_s)) begin
              lanes_s[8*i +: 8] = p_ext_s[8 + 8*i +: 8];
              ctrl_s[i]         = 1'b0;
            end else if (i == int'(term_k_s)) begin
              lanes_s[8*i +: 8] = XG_TERM;
              ctrl_s[i]         = 1'b1;
            end else begin
              map_s             = code_to_char(p_ext_s[8 + 7*i +: 7]);
              lanes_s[8*i +: 8] = map_s[7:0];
              ctrl_s[i]         = 1'b1;
              bad_s             = bad_s | ~map_s[8];
            end
          end
        end else begin
          case (btype_s)
            BT_CTRL: begin
              kind_s = BLK_CTRL;
              ctrl_s = 8'hFF;
              for (int i = 0; i < NUM_LANES; i++) begin
                map_s             = code_to_char(p_ext_s[8 + 7*i +: 7]);
                lanes_s[8*i +: 8] = map_s[7:0];
                bad_s             = bad_s | ~map_s[8];
              end
            end
            BT_START0: begin
              kind_s  = BLK_START;
              lanes_s = {payload[63:8], XG_START};
              ctrl_s  = 8'h01;
            end
            BT_START4: begin
              kind_s = BLK_START;
              ctrl_s = 8'h1F;
              for (int i = 0; i < 4; i++) begin
                map_s             = code_to_char(p_ext_s[8 + 7*i +: 7]);
                lanes_s[8*i +: 8] = map_s[7:0];
                bad_s             = bad_s | ~map_s[8];
              end
              lanes_s[39:32] = XG_START;
              lanes_s[63:40] = payload[63:40];
            end
            BT_OS0: begin
              kind_s        = BLK_CTRL;
              ctrl_s        = 8'hF1;
              lanes_s[7:0]  = XG_SEQ;
              lanes_s[31:8] = payload[31:8];
              bad_s         = (payload[35:32] != 4'h0);
              for (int i = 4; i < NUM_LANES; i++) begin
                map_s             = code_to_char(p_ext_s[36 + 7*(i-4) +: 7]);
                lanes_s[8*i +: 8] = map_s[7:0];
                bad_s             = bad_s | ~map_s[8];
              end
            end
            default: bad_s = 1'b1;
          endcase
        end
      end
      default: bad_s = 1'b1;
    endcase
  end

  assign blk.lanes = bad_s ? {NUM_LANES{XG_ERROR}} : lanes_s;
  assign blk.ctrl  = bad_s ? 8'hFF : ctrl_s;
  assign blk.kind  = bad_s ? BLK_INVALID : kind_s;

endmodule

// File: rtl/pcs_64b66b_decoder.sv
// ---------------------------------------------------------------------------
// pcs_64b66b_decoder
// Reassembles 66b blocks from two 32b beats, decodes them, enforces frame
// sequencing and replays each block as two registered XGMII beats.
//   i_clk   : single clock
//   i_reset : synchronous, active-high reset
//   bus     : slave side of pcs_64b66b_decoder_if (input beats in, XGMII out)
// A block whose second beat arrives on cycle N is output on N+1 (lanes 0-3)
// and N+2 (lanes 4-7). A block cut short after its first beat is reported as
// one /E/ block.
// ---------------------------------------------------------------------------
module pcs_64b66b_decoder
  import pcs_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4,
  parameter int HDR_WIDTH  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  pcs_64b66b_decoder_if.slave  bus
);

  localparam logic [DATA_WIDTH-1:0] RXD_IDLE = {(DATA_WIDTH/8){XG_IDLE}};
  localparam logic [CTRL_WIDTH-1:0] RXC_ALL  = {CTRL_WIDTH{1'b1}};

  in_state_e             in_state_r, in_state_nxt_s;
  frame_state_e          frame_r, frame_nxt_s;
  logic [DATA_WIDTH-1:0] word0_r;
  logic [HDR_WIDTH-1:0]  hdr_r;
  logic                  complete_s, abort_s, seq_err_s, emit_err_s;
  dec_blk_t              dec_blk_s;
  logic [63:0]           emit_lanes_s;
  logic [7:0]            emit_ctrl_s;

  logic                  valid_r, err_r, pend_r;
  logic [DATA_WIDTH-1:0] rxd_r, pend_rxd_r;
  logic [CTRL_WIDTH-1:0] rxc_r, pend_rxc_r;

  pcs_block_decode u_block_decode (
    .sync_hdr (hdr_r),
    .payload  ({bus.i_rx_data, word0_r}),
    .blk      (dec_blk_s)
  );

  // Input beat FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      in_state_r <= IN_W0;
    end else begin
      in_state_r <= in_state_nxt_s;
    end
  end

  // Input beat FSM: next state, block-complete and abort strobes
  always_comb begin
    in_state_nxt_s = in_state_r;
    complete_s     = 1'b0;
    abort_s        = 1'b0;
    case (in_state_r)
      IN_W0: begin
        if (bus.i_rx_data_valid) begin
          in_state_nxt_s = IN_W1;
        end else begin
          in_state_nxt_s = IN_W0;
        end
      end
      IN_W1: begin
        in_state_nxt_s = IN_W0;
        if (bus.i_rx_data_valid) begin
          complete_s = 1'b1;
        end else begin
          abort_s = 1'b1;
        end
      end
      default: in_state_nxt_s = IN_W0;
    endcase
  end

  // Capture the first beat and its sync header
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      word0_r <= '0;
      hdr_r   <= '0;
    end else if (in_state_r == IN_W0 && bus.i_rx_data_valid) begin
      word0_r <= bus.i_rx_data;
      hdr_r   <= bus.i_rx_sync_hdr;
    end else begin
      word0_r <= word0_r;
      hdr_r   <= hdr_r;
    end
  end

  // Frame sequencing check and next frame state
  always_comb begin
    seq_err_s   = 1'b0;
    frame_nxt_s = frame_r;
    if (complete_s) begin
      case (dec_blk_s.kind)
        BLK_DATA:  seq_err_s = (frame_r == FR_IDLE);
        BLK_START: seq_err_s = (frame_r == FR_IN_FRAME);
        BLK_CTRL:  seq_err_s = (frame_r == FR_IN_FRAME);
        default:   seq_err_s = 1'b0;
      endcase
    end else begin
      seq_err_s = 1'b0;
    end

    emit_err_s = abort_s | (complete_s & (seq_err_s | (dec_blk_s.kind == BLK_INVALID)));

    if (emit_err_s) begin
      frame_nxt_s = FR_IDLE;
    end else if (complete_s && dec_blk_s.kind == BLK_START) begin
      frame_nxt_s = FR_IN_FRAME;
    end else if (complete_s && dec_blk_s.kind == BLK_TERM) begin
      frame_nxt_s = FR_IDLE;
    end else begin
      frame_nxt_s = frame_r;
    end

    if (emit_err_s) begin
      emit_lanes_s = {NUM_LANES{XG_ERROR}};
      emit_ctrl_s  = 8'hFF;
    end else begin
      emit_lanes_s = dec_blk_s.lanes;
      emit_ctrl_s  = dec_blk_s.ctrl;
    end
  end

  // Frame state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      frame_r <= FR_IDLE;
    end else begin
      frame_r <= frame_nxt_s;
    end
  end

  // Output staging: beat 0 goes out directly, beat 1 is held for one cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_r    <= 1'b0;
      rxd_r      <= RXD_IDLE;
      rxc_r      <= RXC_ALL;
      err_r      <= 1'b0;
      pend_r     <= 1'b0;
      pend_rxd_r <= RXD_IDLE;
      pend_rxc_r <= RXC_ALL;
    end else if (complete_s || abort_s) begin
      valid_r    <= 1'b1;
      rxd_r      <= emit_lanes_s[DATA_WIDTH-1:0];
      rxc_r      <= emit_ctrl_s[CTRL_WIDTH-1:0];
      err_r      <= emit_err_s;
      pend_r     <= 1'b1;
      pend_rxd_r <= emit_lanes_s[2*DATA_WIDTH-1:DATA_WIDTH];
      pend_rxc_r <= emit_ctrl_s[2*CTRL_WIDTH-1:CTRL_WIDTH];
    end else if (pend_r) begin
      valid_r    <= 1'b1;
      rxd_r      <= pend_rxd_r;
      rxc_r      <= pend_rxc_r;
      err_r      <= 1'b0;
      pend_r     <= 1'b0;
      pend_rxd_r <= pend_rxd_r;
      pend_rxc_r <= pend_rxc_r;
    end else begin
      valid_r    <= 1'b0;
      rxd_r      <= RXD_IDLE;
      rxc_r      <= RXC_ALL;
      err_r      <= 1'b0;
      pend_r     <= 1'b0;
      pend_rxd_r <= pend_rxd_r;
      pend_rxc_r <= pend_rxc_r;
    end
  end

  assign bus.o_xgmii_valid  = valid_r;
  assign bus.o_xgmii_rxd    = rxd_r;
  assign bus.o_xgmii_rxc    = rxc_r;
  assign bus.o_decoding_err = err_r;

endmodule

// File: tb/tb_pcs_64b66b_decoder.sv
// ---------------------------------------------------------------------------
// tb_pcs_64b66b_decoder
// Directed blocks with hand-computed XGMII beats pushed to a scoreboard queue;
// a monitor pops and compares every valid output beat.
// ---------------------------------------------------------------------------
module tb_pcs_64b66b_decoder;

  typedef struct packed {
    logic [31:0] rxd;
    logic [3:0]  rxc;
    logic        err;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst;
  beat_t exp_q[$];
  beat_t mon_exp;
  int    n_checks = 0;
  int    n_pass   = 0;
  int    mon_idx  = 0;

  always #5 clk = ~clk;

  pcs_64b66b_decoder_if bus_if ();

  pcs_64b66b_decoder dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus_if)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endfunction

  task automatic push_blk(input logic [31:0] r0, input logic [3:0] c0, input logic e,
                          input logic [31:0] r1, input logic [3:0] c1);
    exp_q.push_back('{rxd: r0, rxc: c0, err: e});
    exp_q.push_back('{rxd: r1, rxc: c1, err: 1'b0});
  endtask

  task automatic push_err_blk();
    push_blk(32'hFEFEFEFE, 4'hF, 1'b1, 32'hFEFEFEFE, 4'hF);
  endtask

  task automatic send_beat0(input logic [1:0] hdr, input logic [63:0] p);
    bus_if.i_rx_data_valid = 1'b1;
    bus_if.i_rx_data       = p[31:0];
    bus_if.i_rx_sync_hdr   = hdr;
    @(posedge clk); #1;
  endtask

  task automatic send_block(input logic [1:0] hdr, input logic [63:0] p);
    send_beat0(hdr, p);
    bus_if.i_rx_data_valid = 1'b1;
    bus_if.i_rx_data       = p[63:32];
    bus_if.i_rx_sync_hdr   = ~hdr;   // header on beat 1 must be ignored
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus_if.i_rx_data_valid = 1'b0;
    bus_if.i_rx_data       = 32'h0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard monitor: compare every presented beat against the queue head
  always @(negedge clk) begin
    if (!rst && bus_if.o_xgmii_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_beat: got rxd=%h rxc=%h err=%b, expected no output",
                 bus_if.o_xgmii_rxd, bus_if.o_xgmii_rxc, bus_if.o_decoding_err);
      end else begin
        mon_exp = exp_q.pop_front();
        check($sformatf("beat%0d", mon_idx),
              {27'h0, bus_if.o_xgmii_rxd, bus_if.o_xgmii_rxc, bus_if.o_decoding_err},
              {27'h0, mon_exp.rxd, mon_exp.rxc, mon_exp.err});
        mon_idx++;
      end
    end else if (!rst && bus_if.o_decoding_err) begin
      n_checks++;
      $display("FAIL err_without_valid: got err=1, expected 0");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] p_all_err;

    rst                    = 1'b1;
    bus_if.i_rx_data_valid = 1'b0;
    bus_if.i_rx_data       = 32'h0;
    bus_if.i_rx_sync_hdr   = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(bus_if.o_xgmii_valid), 64'd0);
    check("rst_rxd",   64'(bus_if.o_xgmii_rxd), 64'h07070707);
    check("rst_rxc",   64'(bus_if.o_xgmii_rxc), 64'hF);
    check("rst_err",   64'(bus_if.o_decoding_err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Data block while IDLE -> sequencing error
    push_err_blk();
    send_block(2'b01, 64'h0706050403020100);

    // Start / data / terminate-7 frame, back to back
    push_blk(32'h030201FB, 4'h1, 1'b0, 32'h07060504, 4'h0);
    send_block(2'b10, 64'h0706050403020178);
    push_blk(32'h13121110, 4'h0, 1'b0, 32'h17161514, 4'h0);
    send_block(2'b01, 64'h1716151413121110);
    push_blk(32'h23222120, 4'h0, 1'b0, 32'hFD262524, 4'h8);
    send_block(2'b10, 64'h26252423222120FF);

    // Idle control block
    push_blk(32'h07070707, 4'hF, 1'b0, 32'h07070707, 4'hF);
    send_block(2'b10, 64'h000000000000001E);

    // Illegal code 7'h2D in lane 0
    push_err_blk();
    send_block(2'b10, 64'h0000000000002D1E);

    // All codes 7'h1E: legal error characters, no err pulse
    p_all_err = 64'h1E;
    for (int i = 0; i < 8; i++) p_all_err[8 + 7*i +: 7] = 7'h1E;
    push_blk(32'hFEFEFEFE, 4'hF, 1'b0, 32'hFEFEFEFE, 4'hF);
    send_block(2'b10, p_all_err);

    // Bad sync headers 11 and 00
    push_err_blk();
    send_block(2'b11, 64'h0000000000000000);
    push_err_blk();
    send_block(2'b00, 64'h1111111111111111);

    // Valid dropped after beat 0, then a full block
    push_err_blk();
    send_beat0(2'b10, 64'h000000000000001E);
    idle(1);
    push_blk(32'h07070707, 4'hF, 1'b0, 32'h07070707, 4'hF);
    send_block(2'b10, 64'h000000000000001E);

    // Start in lane 4, terminate in lane 0
    push_blk(32'h07070707, 4'hF, 1'b0, 32'hC3B2A1FB, 4'h1);
    send_block(2'b10, 64'hC3B2A10000000033);
    push_blk(32'h070707FD, 4'hF, 1'b0, 32'h07070707, 4'hF);
    send_block(2'b10, 64'h0000000000000087);

    // Start, terminate in lane 3
    push_blk(32'h030201FB, 4'h1, 1'b0, 32'h07060504, 4'h0);
    send_block(2'b10, 64'h0706050403020178);
    push_blk(32'hFDCCBBAA, 4'h8, 1'b0, 32'h07070707, 4'hF);
    send_block(2'b10, 64'h00000000CCBBAAB4);

    // Ordered set: O0=0 accepted, O0=1 rejected
    push_blk(32'h3322119C, 4'h1, 1'b0, 32'h07070707, 4'hF);
    send_block(2'b10, 64'h000000003322114B);
    push_err_blk();
    send_block(2'b10, 64'h000000013322114B);

    // Start inside a frame, then data in IDLE after the forced reset of frame state
    push_blk(32'h030201FB, 4'h1, 1'b0, 32'h07060504, 4'h0);
    send_block(2'b10, 64'h0706050403020178);
    push_err_blk();
    send_block(2'b10, 64'h0706050403020178);
    push_err_blk();
    send_block(2'b01, 64'h1716151413121110);
    // Ordered set inside a frame
    push_blk(32'h030201FB, 4'h1, 1'b0, 32'h07060504, 4'h0);
    send_block(2'b10, 64'h0706050403020178);
    push_err_blk();
    send_block(2'b10, 64'h000000003322114B);

    idle(1);
    drain();

    // Reset asserted on the second beat of a block drops it
    send_beat0(2'b10, 64'h000000000000001E);
    rst                    = 1'b1;
    bus_if.i_rx_data_valid = 1'b1;
    bus_if.i_rx_data       = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus_if.i_rx_data_valid = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 64'(bus_if.o_xgmii_valid), 64'd0);
    check("post_rst_rxd",   64'(bus_if.o_xgmii_rxd), 64'h07070707);
    @(posedge clk); #1;

    // Next block resumes with one-cycle latency
    push_blk(32'h07070707, 4'hF, 1'b0, 32'h07070707, 4'hF);
    send_beat0(2'b10, 64'h000000000000001E);
    bus_if.i_rx_data_valid = 1'b1;
    bus_if.i_rx_data       = 32'h0;
    @(negedge clk);
    check("latency_before", 64'(bus_if.o_xgmii_valid), 64'd0);
    @(posedge clk); #1;
    bus_if.i_rx_data_valid = 1'b0;
    @(negedge clk);
    check("latency_n_plus_1", 64'(bus_if.o_xgmii_valid), 64'd1);
    @(posedge clk); #1;
    idle(2);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
